// File: rtl/sw_mode_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : sw_mode_encoder
//  Description : Slide-switch front end. Each raw switch bit passes through a
//                2-flop synchroniser and an independent debounce counter. The
//                debounced vector is priority-encoded (highest index wins) into
//                a registered 4-bit mode code that feeds the mode logic and the
//                7-segment decoder. CODE_IDLE (hyphen) means no switch is on.
//  Options     : SWENC_LATCH_EN - when defined, mode_code keeps the last
//                non-idle code while no switch is on, instead of returning to
//                CODE_IDLE.
//  Revision    : 1.0  initial release
// ============================================================================
module sw_mode_encoder #(
    parameter int         N_SW            = 10,
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [3:0] CODE_IDLE       = 4'hE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_stable,
    output logic [3:0]      mode_code,
    output logic            mode_valid,
    output logic            mode_change,
    output logic            multi_sel
);

    // Counter only has to reach DEBOUNCE_CYCLES-1 before it is cleared.
    localparam int              CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [N_SW-1:0]  C_VEC_ONE  = N_SW'(1);

    logic [N_SW-1:0] r_sync_meta;
    logic [N_SW-1:0] r_sync;
    logic [N_SW-1:0] w_stable;

    logic [3:0]      w_hi_idx;
    logic            w_any;
    logic            w_multi;
    logic [3:0]      w_code_next;

    logic [3:0]      r_code;
    logic            r_valid;
    logic            r_change;
    logic            r_multi;

    // Two-flop synchroniser bringing the asynchronous switch levels into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= sw_raw;
            r_sync      <= r_sync_meta;
        end
    end

    generate
        for (genvar i = 0; i < N_SW; i++) begin : g_debounce
            logic [CNT_W-1:0] r_cnt;
            logic             r_level;

            // A new level must be seen for DEBOUNCE_CYCLES consecutive cycles;
            // any return to the committed level restarts the count from zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (r_sync[i] == r_level) begin
                    r_cnt   <= '0;
                end else if (r_cnt == C_CNT_TERM) begin
                    r_level <= r_sync[i];
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + C_CNT_ONE;
                end
            end

            assign w_stable[i] = r_level;
        end
    endgenerate

    assign sw_stable = w_stable;

    // Priority encode the debounced vector; later (higher) indices override.
    always_comb begin
        w_hi_idx = 4'h0;
        for (int k = 0; k < N_SW; k++) begin
            if (w_stable[k]) begin
                w_hi_idx = 4'(k);
            end
        end
        w_any   = |w_stable;
        // Clearing the lowest set bit leaves something only if two or more were set.
        w_multi = (w_stable & (w_stable - C_VEC_ONE)) != '0;
`ifdef SWENC_LATCH_EN
        w_code_next = w_any ? w_hi_idx : r_code;
`else
        w_code_next = w_any ? w_hi_idx : CODE_IDLE;
`endif
    end

    // Registered encoder outputs; the change pulse accompanies the new code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code   <= CODE_IDLE;
            r_valid  <= 1'b0;
            r_change <= 1'b0;
            r_multi  <= 1'b0;
        end else begin
            r_code   <= w_code_next;
            r_valid  <= w_any;
            r_change <= (w_code_next != r_code);
            r_multi  <= w_multi;
        end
    end

    assign mode_code   = r_code;
    assign mode_valid  = r_valid;
    assign mode_change = r_change;
    assign multi_sel   = r_multi;

endmodule
`default_nettype wire
